// File: rtl/mem_init_loader_if.sv
// Byte-stream handshake plus storage write port shared by mem_init_loader and its environment.
// slave: the loader's view; master: the stream source / storage side.
interface mem_init_loader_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 64
);
    localparam int unsigned NB = DATA_W / 8;

    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_last;
    logic              s_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [NB-1:0]     mem_wstrb;
    logic              mem_wen;
    logic              mem_en;

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, mem_addr, mem_din, mem_wstrb, mem_wen, mem_en
    );

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, mem_addr, mem_din, mem_wstrb, mem_wen, mem_en
    );
endinterface

// File: rtl/mem_init_loader.sv
// Packs a byte stream little-endian into storage words at sequential addresses, with optional
// zero-fill. Defining MEMINIT_CHECKSUM_EN adds a 32-bit wrapping sum of loaded bytes.
module mem_init_loader #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              clear_first,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    mem_init_loader_if.slave  bus,
    output logic              busy,
    output logic              done,
`ifdef MEMINIT_CHECKSUM_EN
    output logic [31:0]       checksum,
`endif
    output logic              err_short
);
    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BW-1:0] ByteLast = BW'(NB - 1);
    localparam logic [BW-1:0] ByteOne = BW'(1);
    localparam logic [ADDR_W:0] CntOne = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {StIdle, StClear, StLoad, StDone} state_e;

    state_e            state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   idx_q;
    logic [DATA_W-1:0] pack_q;
    logic [NB-1:0]     strb_q;
    logic [BW-1:0]     byte_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic [NB-1:0]     wstrb_q;
    logic              wen_q;

    logic              start_ok;
    logic              accept;
    logic [DATA_W-1:0] pack_d;
    logic [NB-1:0]     strb_d;
    logic [ADDR_W:0]   idx_inc;
    logic [ADDR_W-1:0] cur_addr;

    always_comb begin
        start_ok = start && (state == StIdle || state == StDone);
        accept   = ready_q & bus.s_valid;
        pack_d   = pack_q;
        pack_d[{byte_q, 3'b000} +: 8] = bus.s_data;
        strb_d   = strb_q;
        strb_d[byte_q] = 1'b1;
        idx_inc  = idx_q + CntOne;
        // Truncation to ADDR_W bits gives the modulo wrap past the top of storage.
        cur_addr = base_q + idx_q[ADDR_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StIdle;
            base_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            pack_q  <= '0;
            strb_q  <= '0;
            byte_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            wstrb_q <= '0;
            wen_q   <= 1'b0;
        end else begin
            wen_q <= 1'b0;
            unique case (state)
                StIdle, StDone: begin
                    if (start_ok) begin
                        base_q  <= base_addr;
                        count_q <= word_count;
                        idx_q   <= '0;
                        pack_q  <= '0;
                        strb_q  <= '0;
                        byte_q  <= '0;
                        err_q   <= 1'b0;
                        if (word_count == '0) begin
                            state   <= StDone;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b0;
                        end else begin
                            state   <= clear_first ? StClear : StLoad;
                            ready_q <= ~clear_first;
                            done_q  <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                StClear: begin
                    wen_q   <= 1'b1;
                    addr_q  <= cur_addr;
                    din_q   <= '0;
                    wstrb_q <= '1;
                    if (idx_inc == count_q) begin
                        idx_q   <= '0;
                        state   <= StLoad;
                        ready_q <= 1'b1;
                    end else begin
                        idx_q <= idx_inc;
                    end
                end
                StLoad: begin
                    if (accept) begin
                        if (byte_q == ByteLast || bus.s_last) begin
                            // Packer restarts this cycle so the next byte is taken without a bubble.
                            wen_q   <= 1'b1;
                            addr_q  <= cur_addr;
                            din_q   <= pack_d;
                            wstrb_q <= strb_d;
                            idx_q   <= idx_inc;
                            pack_q  <= '0;
                            strb_q  <= '0;
                            byte_q  <= '0;
                            if (idx_inc == count_q || bus.s_last) begin
                                state   <= StDone;
                                ready_q <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                if (idx_inc != count_q) err_q <= 1'b1;
                            end
                        end else begin
                            pack_q <= pack_d;
                            strb_q <= strb_d;
                            byte_q <= byte_q + ByteOne;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef MEMINIT_CHECKSUM_EN
    logic [31:0] sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (start_ok) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= sum_q + {24'd0, bus.s_data};
        end
    end

    assign checksum = sum_q;
`endif

    assign bus.s_ready   = ready_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_din   = din_q;
    assign bus.mem_wstrb = wstrb_q;
    assign bus.mem_wen   = wen_q;
    assign bus.mem_en    = wen_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_short     = err_q;
endmodule

// File: tb/tb_mem_init_loader.sv
// Bench for mem_init_loader: directed operations checked against a queue of expected writes
// built from the operation's parameters and byte list.
module tb_mem_init_loader;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        clear_first;
    logic [11:0] base_addr;
    logic [12:0] word_count;
    logic        busy;
    logic        done;
    logic        err_short;
`ifdef MEMINIT_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    mem_init_loader_if #(.ADDR_W(12), .DATA_W(64)) bus ();

    mem_init_loader #(.ADDR_W(12), .DATA_W(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .clear_first(clear_first),
        .base_addr  (base_addr),
        .word_count (word_count),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
`ifdef MEMINIT_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .err_short  (err_short)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] addr;
        logic [63:0] din;
        logic [7:0]  strb;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] stim[16];
    int         exp_acc;
    int         exp_err;
    logic [31:0] exp_sum;
    int         n_checks = 0;
    int         n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic fill(input logic [7:0] first);
        for (int i = 0; i < 16; i++) stim[i] = first + 8'(i);
    endtask

    // Expected writes: zero-fill range, then bytes grouped into 8-byte words, flushed on s_last.
    task automatic model_build(input logic [11:0] b, input int c, input bit cf, input int nb,
                               input int li);
        int          words;
        int          k;
        logic [63:0] d;
        logic [7:0]  s;
        logic [11:0] a;
        exp_q.delete();
        exp_acc = 0;
        exp_err = 0;
        exp_sum = 0;
        if (cf) begin
            for (int i = 0; i < c; i++) begin
                a = b + 12'(i);
                exp_q.push_back('{addr: a, din: 64'd0, strb: 8'hFF});
            end
        end
        words = 0;
        k = 0;
        d = '0;
        s = '0;
        for (int i = 0; i < nb; i++) begin
            if (words >= c) break;
            d[k*8 +: 8] = stim[i];
            s[k] = 1'b1;
            k++;
            exp_acc++;
            exp_sum = exp_sum + 32'(stim[i]);
            if (k == 8 || i == li) begin
                a = b + 12'(words);
                exp_q.push_back('{addr: a, din: d, strb: s});
                words++;
                k = 0;
                d = '0;
                s = '0;
                if (i == li) begin
                    exp_err = (words < c) ? 1 : 0;
                    break;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        wr_t w;
        if (rst_n) begin
            check("mem_en_vs_wen", 64'(bus.mem_en), 64'(bus.mem_wen));
            if (bus.mem_wen) begin
                check("write_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    check("wr_addr", 64'(bus.mem_addr), 64'(w.addr));
                    check("wr_din", bus.mem_din, w.din);
                    check("wr_strb", 64'(bus.mem_wstrb), 64'(w.strb));
                end
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_ctrl", 64'({bus.s_ready, bus.mem_wen, bus.mem_en, busy, done, err_short}),
              64'd0);
        check("rst_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_din", bus.mem_din, 64'd0);
        check("rst_strb", 64'(bus.mem_wstrb), 64'd0);
`ifdef MEMINIT_CHECKSUM_EN
        check("rst_checksum", 64'(checksum), 64'd0);
`endif
    endtask

    task automatic do_start(input logic [11:0] b, input int c, input bit cf);
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        word_count = 13'(c);
        clear_first = cf;
        @(negedge clk);
        start = 1'b0;
        base_addr = 12'h3AB;
        word_count = 13'd7;
    endtask

    task automatic feed(input int nb, input int li, input bit gaps, input bit poke,
                        output int acc);
        int budget;
        acc = 0;
        for (int i = 0; i < nb; i++) begin
            if (gaps) begin
                bus.s_valid = 1'b0;
                @(negedge clk);
            end
            bus.s_valid = 1'b1;
            bus.s_data = stim[i];
            bus.s_last = (i == li);
            if (poke && i == 5) begin
                start = 1'b1;
                clear_first = 1'b1;
            end
            budget = 0;
            while (!bus.s_ready && !done && budget < 64) begin
                @(negedge clk);
                start = 1'b0;
                budget++;
            end
            if (!bus.s_ready) break;
            @(negedge clk);
            start = 1'b0;
            acc++;
        end
        bus.s_valid = 1'b0;
        bus.s_last = 1'b0;
        start = 1'b0;
    endtask

    task automatic run_op(input logic [11:0] b, input int c, input bit cf, input int nb,
                          input int li, input bit gaps, input bit poke);
        int acc;
        int n;
        model_build(b, c, cf, nb, li);
        do_start(b, c, cf);
        if (c == 0) begin
            check("zero_done_next", 64'(done), 64'd1);
            check("zero_ready", 64'(bus.s_ready), 64'd0);
            acc = 0;
        end else begin
            n = 0;
            while (!bus.s_ready && n < c + 8) begin
                @(negedge clk);
                n++;
            end
            check("ready_latency", 64'(n), cf ? 64'(c) : 64'd0);
            feed(nb, li, gaps, poke, acc);
        end
        n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("accepted", 64'(acc), 64'(exp_acc));
        check("done", 64'(done), 64'd1);
        check("busy", 64'(busy), 64'd0);
        check("ready_after", 64'(bus.s_ready), 64'd0);
        check("err_short", 64'(err_short), 64'(exp_err));
        check("writes_left", 64'(exp_q.size()), 64'd0);
`ifdef MEMINIT_CHECKSUM_EN
        check("checksum", 64'(checksum), 64'(exp_sum));
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        clear_first = 1'b0;
        base_addr = '0;
        word_count = '0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.s_last = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;

        // Reset mid-load after 3 bytes; partial word must vanish.
        fill(8'h51);
        exp_q.delete();
        do_start(12'h040, 2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data = stim[i];
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        fill(8'hA1);
        model_build(12'h020, 1, 1'b0, 8, 7);
        check("model_fresh_din", exp_q[0].din, 64'hA8A7A6A5A4A3A2A1);
        run_op(12'h020, 1, 1'b0, 8, 7, 1'b0, 1'b0);

        // Basic load.
        fill(8'h01);
        model_build(12'h010, 2, 1'b0, 16, 15);
        check("model_basic_w0", exp_q[0].din, 64'h0807060504030201);
        check("model_basic_w1", exp_q[1].din, 64'h100F0E0D0C0B0A09);
        check("model_basic_a1", 64'(exp_q[1].addr), 64'h011);
        check("model_sum", 64'(exp_sum), 64'h88);
        run_op(12'h010, 2, 1'b0, 16, 15, 1'b0, 1'b0);

        // Clear then load across the address wrap.
        fill(8'h21);
        model_build(12'hFFF, 2, 1'b1, 16, 15);
        check("model_wrap_a1", 64'(exp_q[1].addr), 64'h000);
        check("model_wrap_a3", 64'(exp_q[3].addr), 64'h000);
        run_op(12'hFFF, 2, 1'b1, 16, 15, 1'b0, 1'b0);

        // Short stream: 11 bytes for 4 words.
        fill(8'h01);
        model_build(12'h100, 4, 1'b0, 11, 10);
        check("model_short_strb", 64'(exp_q[1].strb), 64'h07);
        check("model_short_din", exp_q[1].din, 64'h00000000000B0A09);
        check("model_short_err", 64'(exp_err), 64'd1);
        run_op(12'h100, 4, 1'b0, 11, 10, 1'b0, 1'b0);

        // Zero count, then overrun with 12 bytes offered for one word.
        run_op(12'h200, 0, 1'b0, 0, -1, 1'b0, 1'b0);
        fill(8'hC0);
        model_build(12'h300, 1, 1'b0, 12, -1);
        check("model_overrun_acc", 64'(exp_acc), 64'd8);
        run_op(12'h300, 1, 1'b0, 12, -1, 1'b0, 1'b0);

        // Gapped stream with a start pulse during LOAD.
        fill(8'h01);
        run_op(12'h010, 2, 1'b0, 16, 15, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
